// File: rtl/nabp_image_ram_sink_if.sv
// Interface bundle for the NABP image-RAM sink. It groups the PE-chain capture
// stream and the host readout port into one set of signals.
interface nabp_image_ram_sink_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  ir_kick;
    logic                  ir_done;
    logic [ADDR_WIDTH-1:0] ir_addr;
    logic [DATA_WIDTH-1:0] ir_val;
    logic                  ir_enable;
    logic                  hs_stall;
    logic                  hs_rd_en;
    logic [ADDR_WIDTH-1:0] hs_rd_addr;
    logic [DATA_WIDTH-1:0] hs_rd_val;
    logic                  hs_frame_ready;
    logic [ADDR_WIDTH:0]   hs_beat_count;
    logic                  hs_err_range;
    logic                  hs_err_protocol;

    modport master (
        output ir_kick, ir_done, ir_addr, ir_val, hs_stall, hs_rd_en, hs_rd_addr,
        input  ir_enable, hs_rd_val, hs_frame_ready, hs_beat_count,
               hs_err_range, hs_err_protocol
    );

    modport slave (
        input  ir_kick, ir_done, ir_addr, ir_val, hs_stall, hs_rd_en, hs_rd_addr,
        output ir_enable, hs_rd_val, hs_frame_ready, hs_beat_count,
               hs_err_range, hs_err_protocol
    );
endinterface

// File: rtl/nabp_image_ram_sink.sv
// NABP image-RAM sink: captures the PE-chain pixel stream into a small FIFO,
// drains it into a single-port image memory, and serves host readback.
module nabp_image_ram_sink #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int IMAGE_SIZE = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    nabp_image_ram_sink_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int BC_W  = ADDR_WIDTH + 1;
    localparam logic [BC_W-1:0]  IMAGE_LIMIT = BC_W'(IMAGE_SIZE);
    localparam logic [BC_W-1:0]  BEAT_MAX    = '1;
    localparam logic [CNT_W-1:0] FILL_LIMIT  = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]      fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_val  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem       [IMAGE_SIZE];

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  enable_q, enable_d;
    logic [DATA_WIDTH-1:0] rd_val_q;
    logic [BC_W-1:0]       beat_count_q;
    logic                  err_range_q, err_protocol_q;

    logic beat, addr_ok, push, pop, new_frame, proto_bad;

    assign beat    = (state_q == RECV) && enable_q && !bus.ir_done;
    assign addr_ok = {1'b0, bus.ir_addr} < IMAGE_LIMIT;
    assign push    = beat && addr_ok;
    // Host reads own the single memory port, so the drain yields to them.
    assign pop     = (count_q != '0) && !bus.hs_rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        new_frame = 1'b0;
        proto_bad = 1'b0;
        unique case (state_q)
            IDLE, DONE: if (bus.ir_kick) begin
                state_d   = RECV;
                new_frame = 1'b1;
            end
            RECV:  if (bus.ir_done && !bus.ir_kick) state_d = DRAIN;
            DRAIN: if (count_q == '0) state_d = DONE;
        endcase
        if (bus.ir_kick && (state_q == RECV || state_q == DRAIN)) proto_bad = 1'b1;
        if (bus.ir_done && state_q != RECV) proto_bad = 1'b1;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

        // Leaving room for one more beat covers the beat already in flight next cycle.
        enable_d = (state_d == RECV) && !bus.hs_stall && (count_d <= FILL_LIMIT);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            enable_q <= enable_d;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_count_q   <= '0;
            err_range_q    <= 1'b0;
            err_protocol_q <= 1'b0;
        end else if (new_frame) begin
            beat_count_q   <= '0;
            err_range_q    <= 1'b0;
            err_protocol_q <= proto_bad;
        end else begin
            if (push && beat_count_q != BEAT_MAX) beat_count_q <= beat_count_q + 1'b1;
            if (beat && !addr_ok) err_range_q <= 1'b1;
            if (proto_bad) err_protocol_q <= 1'b1;
        end
    end

    // NOTE: FIFO storage and image memory carry no reset; occupancy is tracked by the reset pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.ir_addr[IDX_W-1:0];
            fifo_val[wr_ptr]  <= bus.ir_val;
        end
        if (pop) mem[fifo_addr[rd_ptr]] <= fifo_val[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_val_q <= '0;
        end else if (bus.hs_rd_en) begin
            rd_val_q <= ({1'b0, bus.hs_rd_addr} < IMAGE_LIMIT)
                      ? mem[bus.hs_rd_addr[IDX_W-1:0]] : '0;
        end
    end

    assign bus.ir_enable       = enable_q;
    assign bus.hs_rd_val       = rd_val_q;
    assign bus.hs_frame_ready  = (state_q == DONE);
    assign bus.hs_beat_count   = beat_count_q;
    assign bus.hs_err_range    = err_range_q;
    assign bus.hs_err_protocol = err_protocol_q;
endmodule

// File: tb/tb_nabp_image_ram_sink.sv
// Directed bench for nabp_image_ram_sink: frames, back-pressure, range and
// protocol errors, and host readback against hand-computed values.
module tb_nabp_image_ram_sink;
    localparam int AW = 13;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    nabp_image_ram_sink_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    nabp_image_ram_sink #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMAGE_SIZE(4096), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_beat(input logic [AW-1:0] a, input logic [DW-1:0] v);
        int guard = 0;
        while (!bus.ir_enable && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("enable_timeout", 32'd0, 32'd1);
        bus.ir_addr = a;
        bus.ir_val  = v;
        tick();
    endtask

    task automatic kick();
        bus.ir_kick = 1'b1;
        tick();
        bus.ir_kick = 1'b0;
    endtask

    task automatic done_with(input logic [AW-1:0] a, input logic [DW-1:0] v);
        bus.ir_addr = a;
        bus.ir_val  = v;
        bus.ir_done = 1'b1;
        tick();
        bus.ir_done = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.hs_frame_ready && n < 3) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.hs_frame_ready), 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.hs_rd_en   = 1'b1;
        bus.hs_rd_addr = a;
        tick();
        bus.hs_rd_en   = 1'b0;
        check(tag, 32'(bus.hs_rd_val), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enable"}, 32'(bus.ir_enable), 32'd0);
        check({tag, "_rd_val"}, 32'(bus.hs_rd_val), 32'd0);
        check({tag, "_ready"},  32'(bus.hs_frame_ready), 32'd0);
        check({tag, "_count"},  32'(bus.hs_beat_count), 32'd0);
        check({tag, "_erange"}, 32'(bus.hs_err_range), 32'd0);
        check({tag, "_eproto"}, 32'(bus.hs_err_protocol), 32'd0);
    endtask

    initial begin
        bus.ir_kick = 1'b0;  bus.ir_done = 1'b0;
        bus.ir_addr = '0;    bus.ir_val = '0;
        bus.hs_stall = 1'b0; bus.hs_rd_en = 1'b0; bus.hs_rd_addr = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check_reset_outputs("por");

        // ir_done while idle: flagged, no state change
        done_with(13'd0, 16'd0);
        check("done_idle_eproto", 32'(bus.hs_err_protocol), 32'd1);
        check("done_idle_ready",  32'(bus.hs_frame_ready), 32'd0);
        check("done_idle_enable", 32'(bus.ir_enable), 32'd0);

        // two beats parked in the FIFO, then reset mid-frame
        bus.hs_rd_en = 1'b1;
        kick();
        check("kick_clears_eproto", 32'(bus.hs_err_protocol), 32'd0);
        put_beat(13'd100, 16'h0100);
        put_beat(13'd101, 16'h0101);
        check("pre_reset_count", 32'(bus.hs_beat_count), 32'd2);
        reset_n = 1'b0;
        bus.hs_rd_en = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        reset_n = 1'b1;
        tick();

        // 16-beat frame, val = addr*3
        kick();
        check("kick_enable", 32'(bus.ir_enable), 32'd1);
        for (int i = 0; i < 16; i++) put_beat(AW'(i), DW'(i * 3));
        done_with(13'd0, 16'd0);
        wait_ready("f16_ready");
        check("f16_count", 32'(bus.hs_beat_count), 32'd16);
        read_check("f16_rd7", 13'd7, 16'd21);
        tick();
        check("rd_val_hold", 32'(bus.hs_rd_val), 32'd21);
        read_check("f16_rd15", 13'd15, 16'd45);

        // back-pressure: host read held through the start of a 10-beat frame
        bus.hs_rd_en   = 1'b1;
        bus.hs_rd_addr = 13'd0;
        kick();
        for (int i = 0; i < 3; i++) put_beat(AW'(20 + i), DW'(16'h0100 + i));
        check("bp_enable_low", 32'(bus.ir_enable), 32'd0);
        tick(); tick();
        check("bp_enable_still_low", 32'(bus.ir_enable), 32'd0);
        check("bp_count3", 32'(bus.hs_beat_count), 32'd3);
        bus.hs_rd_en = 1'b0;
        for (int i = 3; i < 10; i++) put_beat(AW'(20 + i), DW'(16'h0100 + i));
        done_with(13'd0, 16'd0);
        wait_ready("bp_ready");
        check("bp_count10", 32'(bus.hs_beat_count), 32'd10);
        for (int i = 0; i < 10; i++) read_check($sformatf("bp_rd%0d", i), AW'(20 + i), DW'(16'h0100 + i));

        // out-of-range beat, stall pulse, beat discarded in the done cycle
        kick();
        put_beat(13'd4096, 16'hDEAD);
        check("range_err", 32'(bus.hs_err_range), 32'd1);
        check("range_not_counted", 32'(bus.hs_beat_count), 32'd0);
        put_beat(13'd1, 16'h1111);
        bus.hs_stall = 1'b1;
        put_beat(13'd2, 16'h2222);
        bus.hs_stall = 1'b0;
        check("stall_enable_low", 32'(bus.ir_enable), 32'd0);
        tick();
        check("stall_release_enable", 32'(bus.ir_enable), 32'd1);
        done_with(13'd3, 16'h3333);
        wait_ready("rng_ready");
        check("rng_count", 32'(bus.hs_beat_count), 32'd2);
        check("rng_err_sticky", 32'(bus.hs_err_range), 32'd1);
        read_check("rng_rd1", 13'd1, 16'h1111);
        read_check("rng_rd2", 13'd2, 16'h2222);
        read_check("done_beat_dropped", 13'd3, 16'd9);
        read_check("rd_out_of_range", 13'd4096, 16'd0);

        // two frames writing addr 5; kick during RECV is flagged but ignored
        kick();
        put_beat(13'd5, 16'hAAAA);
        bus.ir_kick = 1'b1;
        put_beat(13'd6, 16'h0606);
        bus.ir_kick = 1'b0;
        check("kick_recv_eproto", 32'(bus.hs_err_protocol), 32'd1);
        check("kick_recv_enable", 32'(bus.ir_enable), 32'd1);
        done_with(13'd0, 16'd0);
        wait_ready("fa_ready");
        check("fa_count", 32'(bus.hs_beat_count), 32'd2);
        read_check("fa_rd5", 13'd5, 16'hAAAA);
        kick();
        check("fb_ready_drop", 32'(bus.hs_frame_ready), 32'd0);
        check("fb_eproto_clear", 32'(bus.hs_err_protocol), 32'd0);
        check("fb_count_clear", 32'(bus.hs_beat_count), 32'd0);
        put_beat(13'd5, 16'h5555);
        done_with(13'd0, 16'd0);
        wait_ready("fb_ready");
        read_check("fb_rd5", 13'd5, 16'h5555);
        read_check("fb_rd6", 13'd6, 16'h0606);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
